// File: rtl/game_pkg.sv
// Shared encodings for the game-flow controller: screen/state codes, winner codes and
// the health width.
package game_pkg;

    typedef enum logic [1:0] {
        SCR_MENU      = 2'd0,
        SCR_COUNTDOWN = 2'd1,
        SCR_FIGHT     = 2'd2,
        SCR_GAMEOVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam int unsigned HEALTH_W = 4;

endpackage

// File: rtl/tick_gen.sv
// Game "second" tick generator: counts clk cycles while enabled, pulses tick on the last
// count of each period and wraps. clear restarts the period.
module tick_gen #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = enable && (cnt_q == CntMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game-state controller: menu handshake, start countdown, fight round timer,
// KO/timeout winner decision and key-qualified return to the menu.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES   = 50_000_000,
    parameter int unsigned COUNT_FROM    = 3,
    parameter int unsigned ROUND_SECONDS = 99,
    parameter int unsigned HOLD_CYCLES   = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_game,
    input  logic                sw0_mode_select,
    input  logic                key_pressed,
    input  logic [HEALTH_W-1:0] p1_health,
    input  logic [HEALTH_W-1:0] p2_health,
    output logic [1:0]          screen_sel,
    output logic                menu_reset,
    output logic                two_player,
    output logic                fight_active,
    output logic [1:0]          countdown_value,
    output logic [6:0]          round_time,
    output logic [1:0]          winner
);
    localparam int unsigned HoldW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HoldW-1:0] HoldMax   = HoldW'(HOLD_CYCLES);
    localparam logic [1:0]       CountInit = 2'(COUNT_FROM);
    localparam logic [6:0]       RoundInit = 7'(ROUND_SECONDS);

    state_t           state_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic             prev_key_q;
    logic             tick, tick_en, tick_clr, key_edge, p1_ko, p2_ko;

    assign screen_sel = state_q;
    assign key_edge   = key_pressed & ~prev_key_q;
    assign p1_ko      = (p1_health == '0);
    assign p2_ko      = (p2_health == '0);
    assign tick_en    = (state_q == SCR_COUNTDOWN) || (state_q == SCR_FIGHT);
    // Restart the tick period on entry to COUNTDOWN and to FIGHT.
    assign tick_clr   = ((state_q == SCR_MENU) && start_game) ||
                        ((state_q == SCR_COUNTDOWN) && tick && (countdown_value == 2'd1));

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= SCR_MENU;
            menu_reset      <= 1'b0;
            two_player      <= 1'b0;
            fight_active    <= 1'b0;
            countdown_value <= 2'd0;
            round_time      <= RoundInit;
            winner          <= WIN_NONE;
            hold_cnt_q      <= '0;
            prev_key_q      <= 1'b0;
        end else begin
            prev_key_q <= key_pressed;
            menu_reset <= 1'b0;
            unique case (state_q)
                SCR_MENU: begin
                    if (start_game) begin
                        two_player      <= sw0_mode_select;
                        countdown_value <= CountInit;
                        state_q         <= SCR_COUNTDOWN;
                    end
                end
                SCR_COUNTDOWN: begin
                    if (tick) begin
                        if (countdown_value > 2'd1) begin
                            countdown_value <= countdown_value - 2'd1;
                        end else begin
                            countdown_value <= 2'd0;
                            round_time      <= RoundInit;
                            fight_active    <= 1'b1;
                            state_q         <= SCR_FIGHT;
                        end
                    end
                end
                SCR_FIGHT: begin
                    // KO takes priority over a timeout landing in the same cycle.
                    if (p1_ko || p2_ko) begin
                        winner       <= (p1_ko && p2_ko) ? WIN_DRAW : (p1_ko ? WIN_P2 : WIN_P1);
                        fight_active <= 1'b0;
                        hold_cnt_q   <= '0;
                        state_q      <= SCR_GAMEOVER;
                    end else if (tick) begin
                        if (round_time <= 7'd1) begin
                            round_time   <= 7'd0;
                            winner       <= (p1_health > p2_health) ? WIN_P1 :
                                            (p2_health > p1_health) ? WIN_P2 : WIN_DRAW;
                            fight_active <= 1'b0;
                            hold_cnt_q   <= '0;
                            state_q      <= SCR_GAMEOVER;
                        end else begin
                            round_time <= round_time - 7'd1;
                        end
                    end
                end
                SCR_GAMEOVER: begin
                    if (key_edge && (hold_cnt_q == HoldMax)) begin
                        menu_reset <= 1'b1;
                        winner     <= WIN_NONE;
                        round_time <= RoundInit;
                        state_q    <= SCR_MENU;
                    end else if (hold_cnt_q != HoldMax) begin
                        hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    end
                end
                default: state_q <= SCR_MENU;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed game scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against an elapsed-time reference model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int unsigned TICK  = 4;
    localparam int unsigned CNT   = 3;
    localparam int unsigned ROUND = 5;
    localparam int unsigned HOLD  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_game = 1'b0;
    logic       sw0 = 1'b0;
    logic       key = 1'b0;
    logic [3:0] p1 = 4'd15;
    logic [3:0] p2 = 4'd15;
    logic [1:0] screen_sel, countdown_value, winner;
    logic       menu_reset, two_player, fight_active;
    logic [6:0] round_time;

    int total = 0;
    int passed = 0;

    // Reference model: phase plus cycles elapsed in that phase.
    int m_phase, m_el, m_win, m_rt_go;
    bit m_two, m_mr, m_prev;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .TICK_CYCLES   (TICK),
        .COUNT_FROM    (CNT),
        .ROUND_SECONDS (ROUND),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_game      (start_game),
        .sw0_mode_select (sw0),
        .key_pressed     (key),
        .p1_health       (p1),
        .p2_health       (p2),
        .screen_sel      (screen_sel),
        .menu_reset      (menu_reset),
        .two_player      (two_player),
        .fight_active    (fight_active),
        .countdown_value (countdown_value),
        .round_time      (round_time),
        .winner          (winner)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0; m_el = 0; m_win = 0; m_rt_go = ROUND;
        m_two = 1'b0; m_mr = 1'b0; m_prev = 1'b0;
    endtask

    function automatic int m_rt();
        if (m_phase == 2) return ROUND - m_el / TICK;
        if (m_phase == 3) return m_rt_go;
        return ROUND;
    endfunction

    task automatic model_step();
        bit mr;
        mr = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (start_game) begin m_two = sw0; m_phase = 1; m_el = 0; end
                1: if (m_el == CNT * TICK - 1) begin m_phase = 2; m_el = 0; end
                   else m_el++;
                2: begin
                    if (p1 == 0 || p2 == 0) begin
                        m_win = (p1 == 0 && p2 == 0) ? 3 : (p1 == 0 ? 2 : 1);
                        m_rt_go = ROUND - m_el / TICK;
                        m_phase = 3; m_el = 0;
                    end else if (m_el == ROUND * TICK - 1) begin
                        m_win = (p1 > p2) ? 1 : ((p2 > p1) ? 2 : 3);
                        m_rt_go = 0;
                        m_phase = 3; m_el = 0;
                    end else m_el++;
                end
                default: if (key && !m_prev && m_el >= HOLD) begin m_phase = 0; mr = 1'b1; end
                         else m_el++;
            endcase
            m_mr = mr;
            m_prev = key;
        end
    endtask

    task automatic compare_all();
        check("screen_sel", screen_sel, m_phase);
        check("menu_reset", menu_reset, m_mr);
        check("two_player", two_player, m_two);
        check("fight_active", fight_active, m_phase == 2);
        check("countdown_value", countdown_value, (m_phase == 1) ? CNT - m_el / TICK : 0);
        check("round_time", round_time, m_rt());
        check("winner", winner, (m_phase == 3) ? m_win : 0);
    endtask

    task automatic cycle(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic start_fight(input bit sw);
        start_game = 1'b1; sw0 = sw;
        cycle();
        start_game = 1'b0;
        check("lit_cd_screen", screen_sel, 1);
        check("lit_cd_two_player", two_player, sw);
        check("lit_cd_first", countdown_value, 3);
        cycle(3);
        check("lit_cd_3_last", countdown_value, 3);
        cycle(1);
        check("lit_cd_2", countdown_value, 2);
        cycle(8);
        check("lit_fight_screen", screen_sel, 2);
        check("lit_fight_active", fight_active, 1);
        check("lit_fight_rt", round_time, 5);
    endtask

    task automatic leave_over();
        key = 1'b0;
        cycle(HOLD + 1);
        key = 1'b1;
        cycle();
        check("lit_exit_screen", screen_sel, 0);
        check("lit_exit_menu_reset", menu_reset, 1);
        check("lit_exit_winner", winner, 0);
        key = 1'b0;
        cycle();
        check("lit_menu_reset_pulse", menu_reset, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        check("lit_reset_rt", round_time, 5);
        reset = 1'b0;
        cycle(2);

        // KO by p2 with key held from FIGHT into GAME_OVER; spurious start_game in FIGHT.
        start_fight(1'b1);
        key = 1'b1;
        cycle(2);
        start_game = 1'b1;
        cycle();
        start_game = 1'b0;
        check("lit_spurious_start", screen_sel, 2);
        p2 = 4'd0;
        cycle();
        p2 = 4'd15;
        check("lit_ko_screen", screen_sel, 3);
        check("lit_ko_winner", winner, 1);
        check("lit_ko_fight_active", fight_active, 0);
        cycle(12);
        check("lit_held_key_stays", screen_sel, 3);
        leave_over();
        check("lit_two_player_kept", two_player, 1);

        // Timeout with p2 ahead; early press ignored, press at hold boundary accepted.
        start_fight(1'b0);
        p1 = 4'd7; p2 = 4'd9;
        cycle(19);
        check("lit_rt_last", round_time, 1);
        cycle();
        check("lit_to_screen", screen_sel, 3);
        check("lit_to_rt", round_time, 0);
        check("lit_to_winner", winner, 2);
        key = 1'b0;
        cycle(3);
        key = 1'b1;
        cycle();
        check("lit_early_press", screen_sel, 3);
        key = 1'b0;
        cycle(4);
        key = 1'b1;
        cycle();
        check("lit_boundary_press", screen_sel, 0);
        check("lit_boundary_menu_reset", menu_reset, 1);
        key = 1'b0;
        cycle();

        // Timeout with equal health.
        start_fight(1'b0);
        p1 = 4'd5; p2 = 4'd5;
        cycle(20);
        check("lit_draw_timeout", winner, 3);
        leave_over();

        // Double KO.
        start_fight(1'b1);
        p1 = 4'd0; p2 = 4'd0;
        cycle();
        check("lit_double_ko", winner, 3);
        p1 = 4'd15; p2 = 4'd15;
        leave_over();

        // KO on the final timeout tick: KO wins, round_time frozen at 1.
        start_fight(1'b0);
        p1 = 4'd9; p2 = 4'd9;
        cycle(19);
        p1 = 4'd0;
        cycle();
        p1 = 4'd15;
        check("lit_ko_on_tick_winner", winner, 2);
        check("lit_ko_on_tick_rt", round_time, 1);
        leave_over();

        // Async reset mid-COUNTDOWN.
        start_game = 1'b1;
        cycle();
        start_game = 1'b0;
        cycle(5);
        reset = 1'b1;
        #1;
        check("lit_async_screen", screen_sel, 0);
        check("lit_async_cd", countdown_value, 0);
        check("lit_async_menu_reset", menu_reset, 0);
        model_reset();
        cycle();
        reset = 1'b0;
        cycle(2);

        // Randomized stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            start_game = ($urandom_range(0, 4) == 0);
            sw0 = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) key = ~key;
            p1 = ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            p2 = ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
